mem_arbiter: RTL and testbench

- Shares the single external memory port (req / req_data / resp channels) between the instruction cache and the data cache inside riscv_top.
- Arbitrates requests round-robin and locks the port to a writer until all write-data beats are sent.
- Routes responses back by the requester-ID bit carried in the tag MSB.

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_rr_arb2.sv | 26 ++
 rtl/mem_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the I$/D$ memory-port arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WDATA = 2'd2
  } state_e;

  localparam logic CLIENT_IC = 1'b0;
  localparam logic CLIENT_DC = 1'b1;

  // The requester ID travels in the MSB of the memory-side tag.
  function automatic int unsigned tag_id_bit(input int unsigned tag_bits);
    return tag_bits - 1;
  endfunction

  function automatic int unsigned beat_cnt_bits(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin selector; a tie goes to the client not granted last.
module mem_arbiter_rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic       o_grant_c
);

  logic r_last_grant;

  always_comb begin
    o_grant_c = ~r_last_grant;
    if (i_req == 2'b01)      o_grant_c = CLIENT_IC;
    else if (i_req == 2'b10) o_grant_c = CLIENT_DC;
  end

  // Reset to DC so the IC wins the first tie.
  always_ff @(posedge clk) begin
    if (!reset)        r_last_grant <= CLIENT_DC;
    else if (i_update) r_last_grant <= o_grant_c;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between I$ and D$; locks to a writer until all beats are sent.
// Optional macro MEM_ARB_PERF_CNT_EN adds grant and wait counters.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = 28,
  parameter int unsigned DATA_BITS  = 128,
  parameter int unsigned TAG_BITS   = 5,
  parameter int unsigned DATA_BEATS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ic_req_valid,
  output logic                   ic_req_ready,
  input  logic                   ic_req_rw,
  input  logic [ADDR_BITS-1:0]   ic_req_addr,
  input  logic [TAG_BITS-2:0]    ic_req_tag,
  input  logic                   ic_req_data_valid,
  output logic                   ic_req_data_ready,
  input  logic [DATA_BITS-1:0]   ic_req_data_bits,
  input  logic [DATA_BITS/8-1:0] ic_req_data_mask,
  output logic                   ic_resp_valid,
  output logic [TAG_BITS-2:0]    ic_resp_tag,
  output logic [DATA_BITS-1:0]   ic_resp_data,
  input  logic                   dc_req_valid,
  output logic                   dc_req_ready,
  input  logic                   dc_req_rw,
  input  logic [ADDR_BITS-1:0]   dc_req_addr,
  input  logic [TAG_BITS-2:0]    dc_req_tag,
  input  logic                   dc_req_data_valid,
  output logic                   dc_req_data_ready,
  input  logic [DATA_BITS-1:0]   dc_req_data_bits,
  input  logic [DATA_BITS/8-1:0] dc_req_data_mask,
  output logic                   dc_resp_valid,
  output logic [TAG_BITS-2:0]    dc_resp_tag,
  output logic [DATA_BITS-1:0]   dc_resp_data,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_req_rw,
  output logic [ADDR_BITS-1:0]   mem_req_addr,
  output logic [TAG_BITS-1:0]    mem_req_tag,
  output logic                   mem_req_data_valid,
  input  logic                   mem_req_data_ready,
  output logic [DATA_BITS-1:0]   mem_req_data_bits,
  output logic [DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                   mem_resp_valid,
  input  logic [TAG_BITS-1:0]    mem_resp_tag,
  input  logic [DATA_BITS-1:0]   mem_resp_data
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]            ic_grant_cnt,
  output logic [31:0]            dc_grant_cnt,
  output logic [31:0]            wait_cnt
`endif
);

  localparam int unsigned MASK_BITS = DATA_BITS / 8;
  localparam int unsigned ID_BIT    = tag_id_bit(TAG_BITS);
  localparam int unsigned CNT_BITS  = beat_cnt_bits(DATA_BEATS);
  localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(DATA_BEATS - 1);

  state_e              r_state;
  logic                r_owner;
  logic [CNT_BITS-1:0] r_beat_cnt;

  logic                 w_grant;
  logic                 w_any_req;
  logic                 w_arb_update;
  logic                 w_own_valid;
  logic                 w_other_valid;
  logic                 w_own_rw;
  logic [ADDR_BITS-1:0] w_own_addr;
  logic [TAG_BITS-2:0]  w_own_tag;
  logic                 w_own_dvalid;
  logic [DATA_BITS-1:0] w_own_dbits;
  logic [MASK_BITS-1:0] w_own_dmask;
  logic                 w_in_req;
  logic                 w_in_wdata;
  logic                 w_req_hs;
  logic                 w_data_hs;

  assign w_any_req    = ic_req_valid | dc_req_valid;
  assign w_arb_update = (r_state == ST_IDLE) && w_any_req;

  mem_arbiter_rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .reset     (reset),
    .i_req     ({dc_req_valid, ic_req_valid}),
    .i_update  (w_arb_update),
    .o_grant_c (w_grant)
  );

  // Owner-side mux of both request channels.
  always_comb begin
    w_own_valid   = ic_req_valid;
    w_other_valid = dc_req_valid;
    w_own_rw      = ic_req_rw;
    w_own_addr    = ic_req_addr;
    w_own_tag     = ic_req_tag;
    w_own_dvalid  = ic_req_data_valid;
    w_own_dbits   = ic_req_data_bits;
    w_own_dmask   = ic_req_data_mask;
    if (r_owner == CLIENT_DC) begin
      w_own_valid   = dc_req_valid;
      w_other_valid = ic_req_valid;
      w_own_rw      = dc_req_rw;
      w_own_addr    = dc_req_addr;
      w_own_tag     = dc_req_tag;
      w_own_dvalid  = dc_req_data_valid;
      w_own_dbits   = dc_req_data_bits;
      w_own_dmask   = dc_req_data_mask;
    end
  end

  // Gating by reset keeps every handshake low while reset is asserted.
  assign w_in_req   = reset && (r_state == ST_REQ);
  assign w_in_wdata = reset && (r_state == ST_WDATA);
  assign w_req_hs   = w_in_req && w_own_valid && mem_req_ready;
  assign w_data_hs  = w_in_wdata && w_own_dvalid && mem_req_data_ready;

  always_comb begin
    mem_req_valid      = w_in_req && w_own_valid;
    mem_req_rw         = w_own_rw;
    mem_req_addr       = w_own_addr;
    mem_req_tag        = {r_owner, w_own_tag};
    ic_req_ready       = w_in_req && (r_owner == CLIENT_IC) && mem_req_ready;
    dc_req_ready       = w_in_req && (r_owner == CLIENT_DC) && mem_req_ready;
    mem_req_data_valid = w_in_wdata && w_own_dvalid;
    mem_req_data_bits  = w_in_wdata ? w_own_dbits : '0;
    mem_req_data_mask  = w_in_wdata ? w_own_dmask : '0;
    ic_req_data_ready  = w_in_wdata && (r_owner == CLIENT_IC) && mem_req_data_ready;
    dc_req_data_ready  = w_in_wdata && (r_owner == CLIENT_DC) && mem_req_data_ready;
  end

  // Responses steer by tag ID bit; data and stripped tag go to both clients.
  always_comb begin
    ic_resp_valid = reset && mem_resp_valid && (mem_resp_tag[ID_BIT] == CLIENT_IC);
    dc_resp_valid = reset && mem_resp_valid && (mem_resp_tag[ID_BIT] == CLIENT_DC);
    ic_resp_tag   = mem_resp_tag[TAG_BITS-2:0];
    dc_resp_tag   = mem_resp_tag[TAG_BITS-2:0];
    ic_resp_data  = mem_resp_data;
    dc_resp_data  = mem_resp_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_owner    <= CLIENT_IC;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_owner <= w_grant;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (w_req_hs) begin
            r_beat_cnt <= '0;
            r_state    <= w_own_rw ? ST_WDATA : ST_IDLE;
          end
        end
        ST_WDATA: begin
          if (w_data_hs) begin
            if (r_beat_cnt == LAST_BEAT) begin
              r_beat_cnt <= '0;
              r_state    <= ST_IDLE;
            end else begin
              r_beat_cnt <= r_beat_cnt + CNT_BITS'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  logic w_grant_ic;
  logic w_grant_dc;
  logic w_waiting;

  assign w_grant_ic = w_arb_update && (w_grant == CLIENT_IC);
  assign w_grant_dc = w_arb_update && (w_grant == CLIENT_DC);
  assign w_waiting  = (r_state != ST_IDLE) && w_other_valid;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ic_grant_cnt <= '0;
      dc_grant_cnt <= '0;
      wait_cnt     <= '0;
    end else begin
      if (w_grant_ic && (ic_grant_cnt != '1)) ic_grant_cnt <= ic_grant_cnt + 32'd1;
      if (w_grant_dc && (dc_grant_cnt != '1)) dc_grant_cnt <= dc_grant_cnt + 32'd1;
      if (w_waiting && (wait_cnt != '1))      wait_cnt     <= wait_cnt + 32'd1;
    end
  end
`else
  logic w_unused_other;
  assign w_unused_other = w_other_valid;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus write/reset sequences.
module tb_mem_arbiter;

  localparam int unsigned AB = 28;
  localparam int unsigned DB = 128;
  localparam int unsigned TB = 5;
  localparam int unsigned MB = DB / 8;
  localparam logic [AB-1:0] IC_A = 28'h0000100;
  localparam logic [AB-1:0] DC_A = 28'h0000200;
  localparam logic [AB-1:0] WR_A = 28'h0000300;

  logic          clk;
  logic          reset;
  logic          ic_req_valid, ic_req_ready, ic_req_rw;
  logic [AB-1:0] ic_req_addr;
  logic [TB-2:0] ic_req_tag;
  logic          ic_req_data_valid, ic_req_data_ready;
  logic [DB-1:0] ic_req_data_bits;
  logic [MB-1:0] ic_req_data_mask;
  logic          ic_resp_valid;
  logic [TB-2:0] ic_resp_tag;
  logic [DB-1:0] ic_resp_data;
  logic          dc_req_valid, dc_req_ready, dc_req_rw;
  logic [AB-1:0] dc_req_addr;
  logic [TB-2:0] dc_req_tag;
  logic          dc_req_data_valid, dc_req_data_ready;
  logic [DB-1:0] dc_req_data_bits;
  logic [MB-1:0] dc_req_data_mask;
  logic          dc_resp_valid;
  logic [TB-2:0] dc_resp_tag;
  logic [DB-1:0] dc_resp_data;
  logic          mem_req_valid, mem_req_ready, mem_req_rw;
  logic [AB-1:0] mem_req_addr;
  logic [TB-1:0] mem_req_tag;
  logic          mem_req_data_valid, mem_req_data_ready;
  logic [DB-1:0] mem_req_data_bits;
  logic [MB-1:0] mem_req_data_mask;
  logic          mem_resp_valid;
  logic [TB-1:0] mem_resp_tag;
  logic [DB-1:0] mem_resp_data;

  int n_pass  = 0;
  int n_total = 0;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_rw(ic_req_rw),
    .ic_req_addr(ic_req_addr), .ic_req_tag(ic_req_tag),
    .ic_req_data_valid(ic_req_data_valid), .ic_req_data_ready(ic_req_data_ready),
    .ic_req_data_bits(ic_req_data_bits), .ic_req_data_mask(ic_req_data_mask),
    .ic_resp_valid(ic_resp_valid), .ic_resp_tag(ic_resp_tag), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
    .dc_req_addr(dc_req_addr), .dc_req_tag(dc_req_tag),
    .dc_req_data_valid(dc_req_data_valid), .dc_req_data_ready(dc_req_data_ready),
    .dc_req_data_bits(dc_req_data_bits), .dc_req_data_mask(dc_req_data_mask),
    .dc_resp_valid(dc_resp_valid), .dc_resp_tag(dc_resp_tag), .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag), .mem_resp_data(mem_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic          rst;
    logic          icv;
    logic [3:0]    ictag;
    logic          dcv;
    logic [3:0]    dctag;
    logic          mrdy;
    logic          rv;
    logic [4:0]    rtag;
    logic          mv;
    logic [4:0]    mtag;
    logic [AB-1:0] maddr;
    logic          icr;
    logic          dcr;
    logic          icrv;
    logic          dcrv;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(
    input logic rst, input logic icv, input logic [3:0] ictag,
    input logic dcv, input logic [3:0] dctag, input logic mrdy,
    input logic rv, input logic [4:0] rtag,
    input logic mv, input logic [4:0] mtag, input logic [AB-1:0] maddr,
    input logic icr, input logic dcr, input logic icrv, input logic dcrv);
    vec_t v;
    v.rst = rst; v.icv = icv; v.ictag = ictag; v.dcv = dcv; v.dctag = dctag;
    v.mrdy = mrdy; v.rv = rv; v.rtag = rtag; v.mv = mv; v.mtag = mtag;
    v.maddr = maddr; v.icr = icr; v.dcr = dcr; v.icrv = icrv; v.dcrv = dcrv;
    return v;
  endfunction

  function automatic logic [DB-1:0] beat_data(input int k);
    return {4{32'hC0DE_0000 + 32'(k)}};
  endfunction

  function automatic logic [MB-1:0] beat_mask(input int k);
    logic [MB-1:0] m;
    m = 16'h000F;
    return m << (4 * k);
  endfunction

  task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [47:0] got_v;
    logic [47:0] exp_v;
    int k;
    int cyc;
    logic mrd;

    reset = 1'b0;
    ic_req_valid = 0; ic_req_rw = 0; ic_req_addr = IC_A; ic_req_tag = '0;
    ic_req_data_valid = 0; ic_req_data_bits = '0; ic_req_data_mask = '0;
    dc_req_valid = 0; dc_req_rw = 0; dc_req_addr = DC_A; dc_req_tag = '0;
    dc_req_data_valid = 0; dc_req_data_bits = '0; dc_req_data_mask = '0;
    mem_req_ready = 0; mem_req_data_ready = 0;
    mem_resp_valid = 0; mem_resp_tag = '0; mem_resp_data = '0;
    repeat (2) @(posedge clk);
    #1;

    //             rst icv ictag dcv dctag mrdy rv rtag    mv mtag   maddr icr dcr icrv dcrv
    vecs[0]  = mk(0, 0, 4'd0, 0, 4'd0, 0, 1, 5'h03,  0, 5'h00, '0,   0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 4'd3, 0, 4'd0, 1, 1, 5'h03,  0, 5'h00, '0,   0, 0, 1, 0);
    vecs[2]  = mk(1, 1, 4'd3, 0, 4'd0, 1, 0, 5'h00,  1, 5'h03, IC_A, 1, 0, 0, 0);
    vecs[3]  = mk(1, 0, 4'd0, 0, 4'd0, 1, 0, 5'h00,  0, 5'h00, '0,   0, 0, 0, 0);
    vecs[4]  = mk(1, 1, 4'd5, 1, 4'd7, 0, 0, 5'h00,  0, 5'h00, '0,   0, 0, 0, 0);
    vecs[5]  = mk(1, 1, 4'd5, 1, 4'd7, 0, 1, 5'h12,  1, 5'h17, DC_A, 0, 0, 0, 1);
    vecs[6]  = mk(1, 1, 4'd5, 1, 4'd7, 1, 0, 5'h00,  1, 5'h17, DC_A, 0, 1, 0, 0);
    vecs[7]  = mk(1, 1, 4'd5, 1, 4'd6, 1, 0, 5'h00,  0, 5'h00, '0,   0, 0, 0, 0);
    vecs[8]  = mk(1, 1, 4'd5, 1, 4'd6, 1, 0, 5'h00,  1, 5'h05, IC_A, 1, 0, 0, 0);
    vecs[9]  = mk(1, 1, 4'd4, 1, 4'd6, 1, 0, 5'h00,  0, 5'h00, '0,   0, 0, 0, 0);
    vecs[10] = mk(1, 1, 4'd4, 1, 4'd6, 1, 0, 5'h00,  1, 5'h16, DC_A, 0, 1, 0, 0);
    vecs[11] = mk(1, 1, 4'd4, 0, 4'd0, 1, 0, 5'h00,  0, 5'h00, '0,   0, 0, 0, 0);
    vecs[12] = mk(1, 1, 4'd4, 0, 4'd0, 1, 0, 5'h00,  1, 5'h04, IC_A, 1, 0, 0, 0);
    vecs[13] = mk(1, 0, 4'd0, 0, 4'd0, 0, 0, 5'h1F,  0, 5'h00, '0,   0, 0, 0, 0);

    for (int i = 0; i < 14; i++) begin
      reset = vecs[i].rst;
      ic_req_valid = vecs[i].icv; ic_req_tag = vecs[i].ictag;
      dc_req_valid = vecs[i].dcv; dc_req_tag = vecs[i].dctag;
      mem_req_ready = vecs[i].mrdy;
      mem_resp_valid = vecs[i].rv; mem_resp_tag = vecs[i].rtag;
      @(negedge clk);
      got_v = {mem_req_valid, mem_req_valid ? mem_req_tag : 5'd0,
               mem_req_valid ? mem_req_rw : 1'b0, mem_req_valid ? mem_req_addr : 28'd0,
               ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid,
               ic_resp_tag, dc_resp_tag, mem_req_data_valid};
      exp_v = {vecs[i].mv, vecs[i].mtag, 1'b0, vecs[i].maddr,
               vecs[i].icr, vecs[i].dcr, vecs[i].icrv, vecs[i].dcrv,
               vecs[i].rtag[3:0], vecs[i].rtag[3:0], 1'b0};
      chk($sformatf("vec%0d", i), 192'(got_v), 192'(exp_v));
      next_cycle();
    end

    // DC write with a stalled request channel and a toggling data channel.
    mem_resp_valid = 0; mem_resp_tag = '0;
    dc_req_valid = 1; dc_req_rw = 1; dc_req_tag = 4'd2; dc_req_addr = WR_A;
    dc_req_data_valid = 1; dc_req_data_bits = beat_data(0); dc_req_data_mask = beat_mask(0);
    mem_req_ready = 0; mem_req_data_ready = 1;
    @(negedge clk);
    chk("wr_idle", 192'({mem_req_valid, mem_req_data_valid, dc_req_data_ready}), 192'(3'b000));
    next_cycle();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("wr_stall%0d", c),
          192'({mem_req_valid, mem_req_tag, mem_req_rw, mem_req_addr, dc_req_ready,
                ic_req_ready, mem_req_data_valid, dc_req_data_ready}),
          192'({1'b1, 5'h12, 1'b1, WR_A, 4'b0000}));
      next_cycle();
    end
    mem_req_ready = 1;
    @(negedge clk);
    chk("wr_accept", 192'({mem_req_valid, dc_req_ready}), 192'(2'b11));
    next_cycle();
    dc_req_valid = 0; mem_req_ready = 0;

    k = 0; cyc = 0;
    while (k < 4 && cyc < 40) begin
      mrd = 1'(cyc % 2);
      dc_req_data_valid = 1; dc_req_data_bits = beat_data(k); dc_req_data_mask = beat_mask(k);
      mem_req_data_ready = mrd;
      if (k >= 1) begin
        ic_req_valid = 1; ic_req_rw = 0; ic_req_tag = 4'd9; ic_req_addr = IC_A;
      end
      @(negedge clk);
      chk($sformatf("beat%0d_data", k), 192'({mem_req_data_bits, mem_req_data_mask}),
          192'({beat_data(k), beat_mask(k)}));
      chk($sformatf("beat%0d_ctl", k),
          192'({mem_req_data_valid, dc_req_data_ready, ic_req_data_ready, mem_req_valid, ic_req_ready}),
          192'({1'b1, mrd, 3'b000}));
      if (mrd) k++;
      next_cycle();
      cyc++;
    end
    chk("beat_count", 192'(k), 192'(4));
    dc_req_data_valid = 0; mem_req_data_ready = 0;
    @(negedge clk);
    chk("post_wr_idle", 192'({mem_req_valid, mem_req_data_valid, ic_req_ready}), 192'(3'b000));
    next_cycle();
    mem_req_ready = 1;
    @(negedge clk);
    chk("ic_after_wr", 192'({mem_req_valid, mem_req_tag, ic_req_ready, mem_req_addr}),
        192'({1'b1, 5'h09, 1'b1, IC_A}));
    next_cycle();
    ic_req_valid = 0;

    // Reset in the middle of a DC write, then a tie after release.
    dc_req_valid = 1; dc_req_rw = 1; dc_req_tag = 4'd2; dc_req_addr = WR_A;
    mem_req_ready = 1;
    next_cycle();
    @(negedge clk);
    chk("rst_wr_req", 192'({mem_req_valid, dc_req_ready, mem_req_tag}), 192'({2'b11, 5'h12}));
    next_cycle();
    dc_req_valid = 0; mem_req_ready = 0;
    dc_req_data_valid = 1; mem_req_data_ready = 1;
    dc_req_data_bits = beat_data(0); dc_req_data_mask = beat_mask(0);
    next_cycle();
    dc_req_data_bits = beat_data(1); dc_req_data_mask = beat_mask(1);
    next_cycle();
    reset = 0;
    dc_req_data_bits = beat_data(2); dc_req_data_mask = beat_mask(2);
    ic_req_valid = 1; ic_req_rw = 0; ic_req_tag = 4'd1; ic_req_addr = IC_A;
    dc_req_valid = 1; dc_req_rw = 0; dc_req_tag = 4'd2;
    mem_req_ready = 1;
    @(negedge clk);
    chk("rst_gate",
        192'({mem_req_data_valid, dc_req_data_ready, ic_req_data_ready, mem_req_valid, ic_req_ready, dc_req_ready}),
        192'(6'b000000));
    next_cycle();
    reset = 1;
    @(negedge clk);
    chk("rst_idle", 192'({mem_req_data_valid, dc_req_data_ready, mem_req_valid}), 192'(3'b000));
    next_cycle();
    @(negedge clk);
    chk("rst_tie_ic", 192'({mem_req_valid, mem_req_tag, dc_req_ready, ic_req_ready, mem_req_data_valid}),
        192'({1'b1, 5'h01, 1'b0, 1'b1, 1'b0}));
    next_cycle();
    ic_req_valid = 0; dc_req_valid = 0; dc_req_data_valid = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
